// File: rtl/lifo_pkg.sv
// Shared definitions for the lifo_param stack: derived widths and the {push,pop} op encoding.
package lifo_pkg;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_REPL = 2'b11
    } op_e;

endpackage

// File: rtl/lifo_param_if.sv
// Push/pop request and status bundle between a stack user (master) and lifo_param (slave).
interface lifo_param_if
    import lifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
);
    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [DATA_W-1:0] top;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              error;

    modport master (
        output push, pop, wr_data,
        input  rd_data, rd_valid, top, count, full, empty, almost_full, error
    );

    modport slave (
        input  push, pop, wr_data,
        output rd_data, rd_valid, top, count, full, empty, almost_full, error
    );

endinterface

// File: rtl/lifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module lifo_mem
    import lifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      i_we,
    input  logic [ptr_w(DEPTH)-1:0]   i_waddr,
    input  logic [DATA_W-1:0]         i_wdata,
    input  logic [ptr_w(DEPTH)-1:0]   i_raddr,
    output logic [DATA_W-1:0]         o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lifo_param.sv
// Parametrised LIFO with replace-on-push+pop, peek, count and almost-full.
// Define LIFO_WRAP_EN to make push-when-full overwrite the oldest entry instead of erroring.
module lifo_param
    import lifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2
) (
    input  logic        clk,
    input  logic        rst,
    lifo_param_if.slave bus
);
    localparam int unsigned CNT_W = cnt_w(DEPTH);
    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [PTR_W-1:0]  r_sp;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_error;

    op_e               w_op;
    logic              w_empty;
    logic              w_full;
    logic [PTR_W-1:0]  w_top_addr;
    logic [DATA_W-1:0] w_top_data;
    logic              w_we;
    logic [PTR_W-1:0]  w_waddr;

    assign w_op       = op_e'({bus.push, bus.pop});
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_top_addr = r_sp - PTR_ONE;

    lifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (bus.wr_data),
        .i_raddr (w_top_addr),
        .o_rdata (w_top_data)
    );

    // When full the ring is closed, so sp already points at the oldest slot.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_sp;
        case (w_op)
            OP_PUSH: begin
`ifdef LIFO_WRAP_EN
                w_we = 1'b1;
`else
                w_we = !w_full;
`endif
            end
            OP_REPL: begin
                w_we    = !w_empty;
                w_waddr = w_top_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sp       <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_error    <= 1'b0;
            case (w_op)
                OP_PUSH: begin
                    if (!w_full) begin
                        r_sp    <= r_sp + PTR_ONE;
                        r_count <= r_count + CNT_ONE;
                    end else begin
`ifdef LIFO_WRAP_EN
                        r_sp <= r_sp + PTR_ONE;
`else
                        r_error <= 1'b1;
`endif
                    end
                end
                OP_POP: begin
                    if (!w_empty) begin
                        r_rd_data  <= w_top_data;
                        r_rd_valid <= 1'b1;
                        r_sp       <= r_sp - PTR_ONE;
                        r_count    <= r_count - CNT_ONE;
                    end else begin
                        r_error <= 1'b1;
                    end
                end
                OP_REPL: begin
                    r_rd_valid <= 1'b1;
                    r_rd_data  <= w_empty ? bus.wr_data : w_top_data;
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_data     = r_rd_data;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.error       = r_error;
    assign bus.count       = r_count;
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.almost_full = (r_count >= CNT_W'(AF_THRESH));
    assign bus.top         = w_empty ? '0 : w_top_data;

endmodule
